// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - two-requester round-robin interval timer with a shared count register
//
// Purpose:
//   Grants one of two requesters a timed interval of LENi+1 cycles.
//   It uses a single shared up-counter.
//   A normal completion is reported with a one-cycle DONE pulse.
//   Dropping the request while it is being served aborts the interval silently.
//
// Ports:
//   CLK     in   rising-edge clock
//   CLR     in   asynchronous active-low reset
//   REQ     in   [1:0]   per-requester interval request, held until DONE or dropped to abort
//   LEN0    in   [W-1:0] interval length for requester 0, sampled at grant
//   LEN1    in   [W-1:0] interval length for requester 1, sampled at grant
//   GNT     out  [1:0]   one-hot grant, high throughout RUN
//   BUSY    out          high in RUN and DONE
//   DONE    out          one-cycle completion pulse
//   DONE_ID out          requester whose interval completed, holds between pulses
//   COUNT   out  [W-1:0] shared count register
module timer_sched #(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         CLR,
   input  logic [1:0]   REQ,
   input  logic [W-1:0] LEN0,
   input  logic [W-1:0] LEN1,
   output logic [1:0]   GNT,
   output logic         BUSY,
   output logic         DONE,
   output logic         DONE_ID,
   output logic [W-1:0] COUNT
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] target_q, target_d;
   logic [1:0]   gnt_q, gnt_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         done_id_q, done_id_d;
   logic         last_q, last_d;
   logic         winner;
   logic         pick;

   always_comb begin
      // The grant register is one-hot during RUN, so its upper bit names the served requester.
      winner    = gnt_q[1];
      // On a tie the requester that was not served last wins.
      // A lone request wins outright.
      pick      = (REQ == 2'b11) ? ~last_q : REQ[1];

      state_d   = state_q;
      count_d   = count_q;
      target_d  = target_q;
      gnt_d     = gnt_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      last_d    = last_q;

      case (state_q)
         S_IDLE: begin
            count_d = '0;
            gnt_d   = 2'b00;
            if (REQ != 2'b00) begin
               state_d  = S_RUN;
               target_d = pick ? LEN1 : LEN0;
               gnt_d    = pick ? 2'b10 : 2'b01;
            end
         end
         S_RUN: begin
            // Abort outranks completion when both happen in the same cycle.
            if (!REQ[winner]) begin
               state_d = S_IDLE;
               gnt_d   = 2'b00;
               count_d = '0;
               last_d  = winner;
            end else if (count_q == target_q) begin
               // COUNT stays at TARGET through the DONE cycle.
               state_d   = S_DONE;
               gnt_d     = 2'b00;
               done_d    = 1'b1;
               done_id_d = winner;
               last_d    = winner;
            end else begin
               count_d = count_q + {{(W-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            count_d = '0;
            gnt_d   = 2'b00;
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
            gnt_d   = 2'b00;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         target_q  <= '0;
         gnt_q     <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         target_q  <= target_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         last_q    <= last_d;
      end
   end

   assign GNT     = gnt_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign DONE_ID = done_id_q;
   assign COUNT   = count_q;

endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - randomized and directed self-checking bench for timer_sched
module tb_timer_sched;

   localparam int W = 4;

   logic         CLK;
   logic         CLR;
   logic [1:0]   REQ;
   logic [W-1:0] LEN0;
   logic [W-1:0] LEN1;
   logic [1:0]   GNT;
   logic         BUSY;
   logic         DONE;
   logic         DONE_ID;
   logic [W-1:0] COUNT;

   int n_checks = 0;
   int n_fails  = 0;

   // Interval-level reference:
   //   m_owner   : requester currently holding an interval (-1 = none)
   //   m_elapsed : cycles already spent in the interval
   //   m_len     : interval length captured at grant
   //   m_pulse   : completion is being reported this cycle
   int m_owner, m_elapsed, m_len, m_last, m_pulse, m_done_id;

   int done_ids[$];

   timer_sched #(.W(W)) dut (
      .CLK    (CLK),
      .CLR    (CLR),
      .REQ    (REQ),
      .LEN0   (LEN0),
      .LEN1   (LEN1),
      .GNT    (GNT),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .DONE_ID(DONE_ID),
      .COUNT  (COUNT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, observed running, required finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fails++;
         $display("FAIL %s: observed %0d, required %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_owner   = -1;
      m_elapsed = 0;
      m_len     = 0;
      m_last    = 1;
      m_pulse   = 0;
      m_done_id = 0;
   endfunction

   function automatic void model_update();
      int r0, r1, who;
      r0 = int'(REQ[0]);
      r1 = int'(REQ[1]);
      if (m_pulse != 0) begin
         m_pulse = 0;
      end else if (m_owner < 0) begin
         if (r0 + r1 > 0) begin
            if (r0 + r1 == 2) who = 1 - m_last;
            else              who = r1;
            m_owner   = who;
            m_len     = (who == 1) ? int'(LEN1) : int'(LEN0);
            m_elapsed = 0;
         end
      end else begin
         if (((m_owner == 1) ? r1 : r0) == 0) begin
            m_last    = m_owner;
            m_owner   = -1;
            m_elapsed = 0;
         end else if (m_elapsed == m_len) begin
            m_pulse   = 1;
            m_done_id = m_owner;
            m_last    = m_owner;
            m_owner   = -1;
         end else begin
            m_elapsed++;
         end
      end
   endfunction

   task automatic compare_all();
      int e_gnt, e_cnt;
      e_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
      e_cnt = (m_owner >= 0) ? m_elapsed : ((m_pulse != 0) ? m_len : 0);
      chk("GNT",     int'(GNT),     e_gnt);
      chk("COUNT",   int'(COUNT),   e_cnt);
      chk("BUSY",    int'(BUSY),    (m_owner >= 0 || m_pulse != 0) ? 1 : 0);
      chk("DONE",    int'(DONE),    m_pulse);
      chk("DONE_ID", int'(DONE_ID), m_done_id);
      chk("GNT_onehot", int'(GNT == 2'b11), 0);
      if (DONE) done_ids.push_back(int'(DONE_ID));
   endtask

   task automatic step(input logic [1:0] r, input logic [W-1:0] l0, input logic [W-1:0] l1);
      REQ  = r;
      LEN0 = l0;
      LEN1 = l1;
      @(posedge CLK);
      model_update();
      @(negedge CLK);
      compare_all();
   endtask

   // Reset pulsed between clock edges: outputs must clear without waiting for an edge.
   task automatic mid_cycle_reset();
      #1 CLR = 1'b0;
      #1;
      model_reset();
      chk("rst_GNT",     int'(GNT),     0);
      chk("rst_COUNT",   int'(COUNT),   0);
      chk("rst_BUSY",    int'(BUSY),    0);
      chk("rst_DONE",    int'(DONE),    0);
      chk("rst_DONE_ID", int'(DONE_ID), 0);
      #1 CLR = 1'b1;
   endtask

   initial begin
      CLR  = 1'b0;
      REQ  = 2'b00;
      LEN0 = '0;
      LEN1 = '0;
      model_reset();
      @(negedge CLK);
      compare_all();
      @(negedge CLK);
      CLR = 1'b1;

      // Single requester, LEN0=3: four RUN cycles, then DONE, then IDLE.
      repeat (5) step(2'b01, 4'd3, 4'd0);
      chk("d028_done",    int'(DONE),    1);
      chk("d028_done_id", int'(DONE_ID), 0);
      chk("d028_count",   int'(COUNT),   3);
      repeat (2) step(2'b00, 4'd3, 4'd0);
      chk("d028_idle_count", int'(COUNT), 0);

      // Held tie: completions must alternate 0,1,0,1.
      mid_cycle_reset();
      done_ids.delete();
      repeat (26) step(2'b11, 4'd2, 4'd5);
      chk("d029_n_done", done_ids.size(), 4);
      for (int i = 0; i < 4 && i < done_ids.size(); i++)
         chk("d029_order", done_ids[i], i % 2);
      repeat (2) step(2'b00, 4'd0, 4'd0);

      // LEN1=0: exactly one RUN cycle.
      step(2'b10, 4'd7, 4'd0);
      chk("d030_gnt",   int'(GNT),   2);
      chk("d030_count", int'(COUNT), 0);
      step(2'b10, 4'd7, 4'd0);
      chk("d030_done",    int'(DONE),    1);
      chk("d030_done_id", int'(DONE_ID), 1);
      repeat (2) step(2'b00, 4'd0, 4'd0);

      // Abort at COUNT=7 of a LEN0=15 interval, then the tie goes to requester 1.
      repeat (8) step(2'b01, 4'd15, 4'd3);
      chk("d031_count7", int'(COUNT), 7);
      step(2'b00, 4'd15, 4'd3);
      chk("d031_abort_gnt",  int'(GNT),  0);
      chk("d031_abort_done", int'(DONE), 0);
      step(2'b11, 4'd15, 4'd3);
      chk("d031_regrant", int'(GNT), 2);
      repeat (2) step(2'b00, 4'd0, 4'd0);

      // Reset mid-interval at COUNT=4; the next tie goes to requester 0.
      repeat (5) step(2'b01, 4'd9, 4'd0);
      chk("d032_count4", int'(COUNT), 4);
      mid_cycle_reset();
      step(2'b11, 4'd9, 4'd2);
      chk("d032_regrant", int'(GNT),  1);
      chk("d032_no_done", int'(DONE), 0);
      repeat (2) step(2'b00, 4'd0, 4'd0);

      // LEN0 changes mid-interval and must be ignored.
      step(2'b01, 4'd4, 4'd0);
      step(2'b01, 4'd4, 4'd0);
      repeat (4) step(2'b01, 4'd1, 4'd9);
      chk("d033_done",  int'(DONE),  1);
      chk("d033_count", int'(COUNT), 4);
      repeat (2) step(2'b00, 4'd0, 4'd0);

      // Random traffic: requests mostly held so intervals complete.
      // Lengths churn every cycle.
      // Drops and resets are occasional.
      begin
         logic [1:0] r;
         r = 2'b00;
         for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) mid_cycle_reset();
            step(r, 4'($urandom), 4'($urandom));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
